word_serializer: RTL

//  Parallel-to-serial front end for the serial FSM detectors, e.g. the multiple-of-4 detector.

---
 rtl/word_serializer_pkg.sv | 19 +
 rtl/ser_bit_counter.sv | 38 +++
 rtl/word_serializer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encodings and a
// counter-width helper.
package word_serializer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 32'sd1;
        while ((32'sd1 << r) < n) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Modulo-N up counter with synchronous clear (priority) and count enable.
// last flags the terminal value N-1.
module ser_bit_counter
    import word_serializer_pkg::*;
#(
    parameter int N  = 2,
    parameter int CW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);

    logic [CW-1:0] cnt_r;
    logic          last_s;

    assign last_s = (cnt_r == CW'(N - 1));

    // Count register: clear wins over enable, wraps after N-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en) begin
            cnt_r <= last_s ? {CW{1'b0}} : cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign last = last_s;

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: accepts WIDTH-bit words on a valid/ready
// handshake and emits one framed bit per clock on x.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter int   GAP       = 0,
    parameter logic IDLE_VAL  = 1'b1,
    parameter int   CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             sof,
    output logic             eof,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int BW = clog2(WIDTH);

    logic [1:0]       state_r, state_n;
    logic [WIDTH-1:0] sh_r, sh_n;
    logic             x_r, x_n;
    logic             x_valid_r, x_valid_n;
    logic             sof_r, sof_n;
    logic             eof_r, eof_n;
    logic [CNT_W-1:0] word_cnt_r;
    logic             cnt_inc_s;

    logic [BW-1:0]    bit_cnt_s;
    logic             bit_last_s;
    logic             gap_last_s;
    logic             gap_end_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             first_bit_s;
    logic             next_bit_s;
    logic [WIDTH-1:0] load_sh_s;
    logic [WIDTH-1:0] next_sh_s;

    ser_bit_counter #(.N(WIDTH), .CW(BW)) u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept_s),
        .en   (state_r == ST_SHIFT),
        .cnt  (bit_cnt_s),
        .last (bit_last_s)
    );

    generate
        if (GAP > 0) begin : g_gap
            localparam int GW = clog2(GAP);
            logic [GW-1:0] gap_cnt_s;
            logic          gap_wrap_s;

            ser_bit_counter #(.N(GAP), .CW(GW)) u_gap_cnt (
                .clk  (clk),
                .rst  (rst),
                .clr  ((state_r == ST_SHIFT) && bit_last_s),
                .en   (state_r == ST_GAP),
                .cnt  (gap_cnt_s),
                .last (gap_wrap_s)
            );

            assign gap_last_s = gap_wrap_s;
            assign gap_end_s  = (gap_cnt_s == GW'(GAP - 1));
        end else begin : g_nogap
            assign gap_last_s = 1'b0;
            assign gap_end_s  = 1'b0;
        end
    endgenerate

    // Ready decode; forced low while the asynchronous reset is asserted.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  in_ready_s = 1'b1;
            ST_SHIFT: in_ready_s = bit_last_s && (GAP == 0);
            ST_GAP:   in_ready_s = gap_last_s;
            default:  in_ready_s = 1'b0;
        endcase
        in_ready_s = in_ready_s & rst;
    end

    assign accept_s = in_valid & in_ready_s;

    // Bit selection: the first bit leaves straight from in_data, the rest from the shift register.
    always_comb begin
        if (MSB_FIRST != 0) begin
            first_bit_s = in_data[WIDTH-1];
            load_sh_s   = {in_data[WIDTH-2:0], 1'b0};
            next_bit_s  = sh_r[WIDTH-1];
            next_sh_s   = {sh_r[WIDTH-2:0], 1'b0};
        end else begin
            first_bit_s = in_data[0];
            load_sh_s   = {1'b0, in_data[WIDTH-1:1]};
            next_bit_s  = sh_r[0];
            next_sh_s   = {1'b0, sh_r[WIDTH-1:1]};
        end
    end

    // Next-state and next-output decode; outputs describe the cycle after the edge.
    always_comb begin
        state_n   = state_r;
        sh_n      = sh_r;
        x_n       = IDLE_VAL;
        x_valid_n = 1'b0;
        sof_n     = 1'b0;
        eof_n     = 1'b0;
        cnt_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n   = ST_SHIFT;
                    sh_n      = load_sh_s;
                    x_n       = first_bit_s;
                    x_valid_n = 1'b1;
                    sof_n     = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!bit_last_s) begin
                    sh_n      = next_sh_s;
                    x_n       = next_bit_s;
                    x_valid_n = 1'b1;
                    eof_n     = (bit_cnt_s == BW'(WIDTH - 2));
                end else begin
                    cnt_inc_s = 1'b1;
                    if (GAP > 0) begin
                        state_n = ST_GAP;
                    end else if (accept_s) begin
                        state_n   = ST_SHIFT;
                        sh_n      = load_sh_s;
                        x_n       = first_bit_s;
                        x_valid_n = 1'b1;
                        sof_n     = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_end_s) begin
                    if (accept_s) begin
                        state_n   = ST_SHIFT;
                        sh_n      = load_sh_s;
                        x_n       = first_bit_s;
                        x_valid_n = 1'b1;
                        sof_n     = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_GAP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, shift register, framed outputs and completed-word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            sh_r       <= {WIDTH{1'b0}};
            x_r        <= IDLE_VAL;
            x_valid_r  <= 1'b0;
            sof_r      <= 1'b0;
            eof_r      <= 1'b0;
            word_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_n;
            sh_r      <= sh_n;
            x_r       <= x_n;
            x_valid_r <= x_valid_n;
            sof_r     <= sof_n;
            eof_r     <= eof_n;
            if (cnt_inc_s) begin
                word_cnt_r <= word_cnt_r + CNT_W'(1'b1);
            end else begin
                word_cnt_r <= word_cnt_r;
            end
        end
    end

    assign in_ready = in_ready_s;
    assign x        = x_r;
    assign x_valid  = x_valid_r;
    assign sof      = sof_r;
    assign eof      = eof_r;
    assign word_cnt = word_cnt_r;

endmodule
